// File: rtl/pic_controller.sv
// pic_controller: 8-input programmable interrupt controller.
// Masks and prioritises level requests, drives the CPU INT pin, supplies the
// interrupt vector during intack and tracks in-service levels for nesting.
// Register map: addr 0 = IMR (read/write), addr 1 = {ISR, IRR} read / EOI write.
// Handshake: int_out is raised for a latched winner; the CPU answers with
// intack, which moves the winner into ISR; the CPU later retires it with EOI.
// Optional build macro PIC_ROTATE_EN: rotating priority driven by a pointer
// that non-specific EOIs update. Without it, irq[0] is highest and irq[7] lowest.
module pic_controller #(
    parameter logic [15:0] VEC_BASE   = 16'h0000,
    parameter logic [7:0]  RESET_MASK = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq,
    input  logic        intack,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        int_out,
    output logic [15:0] vector
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] imr;
    logic [7:0] isr;
    logic [7:0] irr;
    logic [7:0] isr_next;
    logic [2:0] win;
    logic [2:0] ptr;

    logic       irr_found;
    logic [2:0] irr_idx;
    logic [2:0] irr_rank;
    logic       isr_found;
    logic [2:0] isr_idx;
    logic [2:0] isr_rank;
    logic       cand_valid;
    logic       eoi;

    logic       unused_wdata;
    assign unused_wdata = ^wdata[15:8];

    assign eoi = wr_en && addr;

`ifdef PIC_ROTATE_EN
    logic [2:0] rot_ptr;

    // Pointer names the lowest-priority level; a non-specific EOI moves it to the retired level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_ptr <= 3'd7;
        end else if (eoi && wdata[3] && isr_found) begin
            rot_ptr <= isr_idx;
        end
    end

    assign ptr = rot_ptr;
`else
    // Pointer fixed at 7 makes the scan order 0,1,...,7: plain fixed priority.
    assign ptr = 3'd7;
`endif

    // Scan both IRR and ISR in priority order (ptr+1 first) and pick the winners.
    always_comb begin
        irr        = irq & ~imr;
        irr_found  = 1'b0;
        irr_idx    = 3'd0;
        irr_rank   = 3'd7;
        isr_found  = 1'b0;
        isr_idx    = 3'd0;
        isr_rank   = 3'd7;
        for (int k = 0; k < 8; k++) begin
            if (!irr_found && irr[ptr + 3'd1 + 3'(k)]) begin
                irr_found = 1'b1;
                irr_idx   = ptr + 3'd1 + 3'(k);
                irr_rank  = 3'(k);
            end
            if (!isr_found && isr[ptr + 3'd1 + 3'(k)]) begin
                isr_found = 1'b1;
                isr_idx   = ptr + 3'd1 + 3'(k);
                isr_rank  = 3'(k);
            end
        end
        // A request only qualifies if it outranks everything already in service.
        cand_valid = irr_found && (!isr_found || (irr_rank < isr_rank));
    end

    // Next ISR: EOI clear first, then the acknowledge set, so the set wins on the same bit.
    always_comb begin
        isr_next = isr;
        if (eoi) begin
            if (wdata[3]) begin
                if (isr_found) begin
                    isr_next[isr_idx] = 1'b0;
                end
            end else begin
                isr_next[wdata[2:0]] = 1'b0;
            end
        end
        if ((state == REQ) && intack) begin
            isr_next[win] = 1'b1;
        end
    end

    // Request FSM plus mask and in-service registers; int_out is registered and high only in REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            int_out <= 1'b0;
            win     <= 3'd0;
            imr     <= RESET_MASK;
            isr     <= 8'h00;
        end else begin
            isr <= isr_next;
            if (wr_en && !addr) begin
                imr <= wdata[7:0];
            end
            case (state)
                IDLE: begin
                    if (cand_valid) begin
                        win     <= irr_idx;
                        state   <= REQ;
                        int_out <= 1'b1;
                    end
                end
                REQ: begin
                    // win stays frozen here: no re-arbitration once requested.
                    if (intack) begin
                        state   <= SERV;
                        int_out <= 1'b0;
                    end else if (!cand_valid) begin
                        state   <= IDLE;
                        int_out <= 1'b0;
                    end
                end
                SERV: begin
                    if (!intack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_out <= 1'b0;
                end
            endcase
        end
    end

    // Vector is only driven onto the data bus while the CPU acknowledges.
    always_comb begin
        vector = intack ? (VEC_BASE + {13'b0, win}) : 16'h0000;
    end

    // Side-effect-free register read mux.
    always_comb begin
        rdata = 16'h0000;
        if (rd_en) begin
            rdata = addr ? {isr, irr} : {8'h00, imr};
        end
    end

endmodule

// File: tb/tb_pic_controller.sv
// Testbench for pic_controller: directed scenarios plus randomized traffic,
// all checked against a priority-list reference model.
module tb_pic_controller;

    localparam logic [15:0] VB = 16'h0000;
    localparam logic [7:0]  RM = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        intack;
    logic        wr_en;
    logic        rd_en;
    logic        addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        int_out;
    logic [15:0] vector;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0] m_imr;
    logic [7:0] m_isr;
    logic       m_req;
    logic       m_serv;
    logic [2:0] m_win;
    int         m_ptr;

    // clock
    always #5 clk = ~clk;

    pic_controller #(.VEC_BASE(VB), .RESET_MASK(RM)) dut (
        .clk(clk), .rst(rst), .irq(irq), .intack(intack), .wr_en(wr_en),
        .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata),
        .int_out(int_out), .vector(vector)
    );

    // first set level when walking the priority list that starts after p
    function automatic int top_of(input logic [7:0] m, input int p);
        for (int k = 1; k <= 8; k++) begin
            if (m[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // position in the priority list (0 = highest)
    function automatic int pos_of(input int idx, input int p);
        return (idx - p + 7) % 8;
    endfunction

    task automatic model_step();
        logic [7:0] irr;
        logic [7:0] nisr;
        int c;
        int s;
        bit cand;
        if (rst) begin
            m_imr = RM; m_isr = 8'h00; m_req = 1'b0; m_serv = 1'b0; m_win = 3'd0; m_ptr = 7;
        end else begin
            irr  = irq & ~m_imr;
            c    = top_of(irr, m_ptr);
            s    = top_of(m_isr, m_ptr);
            cand = (c >= 0) && ((s < 0) || (pos_of(c, m_ptr) < pos_of(s, m_ptr)));
            nisr = m_isr;
            if (wr_en && addr) begin
                if (wdata[3]) begin
                    if (s >= 0) begin
                        nisr[s] = 1'b0;
`ifdef PIC_ROTATE_EN
                        m_ptr = s;
`endif
                    end
                end else begin
                    nisr[wdata[2:0]] = 1'b0;
                end
            end
            if (m_req) begin
                if (intack) begin
                    nisr[m_win] = 1'b1; m_req = 1'b0; m_serv = 1'b1;
                end else if (!cand) begin
                    m_req = 1'b0;
                end
            end else if (m_serv) begin
                if (!intack) m_serv = 1'b0;
            end else if (cand) begin
                m_win = 3'(c); m_req = 1'b1;
            end
            if (wr_en && !addr) m_imr = wdata[7:0];
            m_isr = nisr;
        end
    endtask

    // driver: advance one clock, update model at the edge, settle
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        irq = 8'h00; intack = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 1'b0; wdata = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL reset_int: got %0b exp 0", int_out); end
        rd_en = 1'b1; addr = 1'b0; #1;
        checks++; if (rdata !== {8'h00, RM}) begin errors++; $display("FAIL reset_imr: got %h exp %h", rdata, {8'h00, RM}); end
        addr = 1'b1; #1;
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h exp 0000", rdata); end
        rd_en = 1'b0; #1;
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL rd_idle: got %h exp 0000", rdata); end
    endtask

    task automatic test_basic();
        irq = 8'h04;
        tick();
        checks++; if (int_out !== 1'b1 || int_out !== m_req) begin errors++; $display("FAIL basic_int: got %0b exp 1", int_out); end
        intack = 1'b1; #1;
        checks++; if (vector !== VB + 16'h0002) begin errors++; $display("FAIL basic_vec: got %h exp %h", vector, VB + 16'h0002); end
        tick();
        rd_en = 1'b1; addr = 1'b1; #1;
        checks++; if (rdata !== 16'h0404) begin errors++; $display("FAIL basic_status: got %h exp 0404", rdata); end
        rd_en = 1'b0; intack = 1'b0;
        #1;
        checks++; if (vector !== 16'h0000) begin errors++; $display("FAIL basic_vec_idle: got %h exp 0000", vector); end
        tick();
        tick();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL basic_insvc: got %0b exp 0", int_out); end
    endtask

    task automatic test_nesting();
        irq = 8'h24;
        tick();
        tick();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL nest_lower: got %0b exp 0", int_out); end
        irq = 8'h26;
        tick();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL nest_higher: got %0b exp 1", int_out); end
        intack = 1'b1; #1;
        checks++; if (vector !== VB + 16'h0001) begin errors++; $display("FAIL nest_vec: got %h exp %h", vector, VB + 16'h0001); end
        tick();
        intack = 1'b0; rd_en = 1'b1; addr = 1'b1; #1;
        checks++; if (rdata[15:8] !== 8'h06) begin errors++; $display("FAIL nest_isr: got %h exp 06", rdata[15:8]); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_eoi();
        irq = 8'h00;
        wr_en = 1'b1; addr = 1'b1; wdata = 16'h0008;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; #1;
        checks++; if (rdata[15:8] !== 8'h04 || rdata[15:8] !== m_isr) begin errors++; $display("FAIL eoi_nonspec: got %h exp 04", rdata[15:8]); end
        rd_en = 1'b0; wr_en = 1'b1; wdata = 16'h0002;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; #1;
        checks++; if (rdata[15:8] !== 8'h00) begin errors++; $display("FAIL eoi_spec: got %h exp 00", rdata[15:8]); end
        rd_en = 1'b0;
    endtask

    task automatic test_mask();
        irq = 8'h04;
        tick();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL mask_req: got %0b exp 1", int_out); end
        wr_en = 1'b1; addr = 1'b0; wdata = 16'h0004;
        tick();
        wr_en = 1'b0;
        tick();
        checks++; if (int_out !== 1'b0 || int_out !== m_req) begin errors++; $display("FAIL mask_drop: got %0b exp 0", int_out); end
        wr_en = 1'b1; wdata = 16'h0000;
        tick();
        wr_en = 1'b0;
        tick();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL mask_reraise: got %0b exp 1", int_out); end
    endtask

    task automatic test_reset_mid();
        irq = 8'hFF;
        wr_en = 1'b1; addr = 1'b0; wdata = 16'h00F0;
        tick();
        wr_en = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (int_out !== 1'b0) begin errors++; $display("FAIL rstmid_int: got %0b exp 0", int_out); end
        rd_en = 1'b1; addr = 1'b0; #1;
        checks++; if (rdata !== {8'h00, RM}) begin errors++; $display("FAIL rstmid_imr: got %h exp %h", rdata, {8'h00, RM}); end
        rd_en = 1'b0; rst = 1'b0;
        tick();
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL rstmid_rise: got %0b exp 1", int_out); end
    endtask

    task automatic serve_one(input logic [15:0] exp_vec, input string tag);
        int n;
        n = 0;
        while (!int_out && n < 8) begin tick(); n++; end
        checks++; if (int_out !== 1'b1) begin errors++; $display("FAIL %s_int: got %0b exp 1", tag, int_out); end
        intack = 1'b1; #1;
        checks++; if (vector !== exp_vec) begin errors++; $display("FAIL %s_vec: got %h exp %h", tag, vector, exp_vec); end
        tick();
        intack = 1'b0;
        tick();
    endtask

    task automatic test_priority_order();
        do_reset();
        irq = 8'h03;
        tick();
        serve_one(VB + 16'h0000, "prio_first");
        wr_en = 1'b1; addr = 1'b1; wdata = 16'h0008;
        tick();
        wr_en = 1'b0;
`ifdef PIC_ROTATE_EN
        serve_one(VB + 16'h0001, "rot_after_eoi");
        irq = 8'h05; wr_en = 1'b1; addr = 1'b1; wdata = 16'h0008;
        tick();
        wr_en = 1'b0;
        serve_one(VB + 16'h0002, "rot_irq2_wins");
`else
        serve_one(VB + 16'h0000, "fixed_irq0_again");
        irq = 8'h05; wr_en = 1'b1; addr = 1'b1; wdata = 16'h0008;
        tick();
        wr_en = 1'b0;
        serve_one(VB + 16'h0000, "fixed_irq0_wins");
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
            intack = (m_req && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 7) == 0);
            wr_en  = ($urandom_range(0, 5) == 0);
            addr   = 1'($urandom_range(0, 1));
            wdata  = 16'($urandom);
            rd_en  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (vector !== (intack ? VB + {13'b0, m_win} : 16'h0000)) begin
                errors++; $display("FAIL rand_vec[%0d]: got %h exp %h", i, vector, intack ? VB + {13'b0, m_win} : 16'h0000);
            end
            checks++;
            if (rdata !== (!rd_en ? 16'h0000 : (addr ? {m_isr, irq & ~m_imr} : {8'h00, m_imr}))) begin
                errors++; $display("FAIL rand_rdata[%0d]: got %h exp %h", i, rdata, !rd_en ? 16'h0000 : (addr ? {m_isr, irq & ~m_imr} : {8'h00, m_imr}));
            end
            tick();
            checks++;
            if (int_out !== m_req) begin errors++; $display("FAIL rand_int[%0d]: got %0b exp %0b", i, int_out, m_req); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_nesting();
        test_eoi();
        test_mask();
        test_reset_mid();
        test_priority_order();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
